// File: rtl/fifo_reader_tx.sv
// fifo_reader_tx: pops words from a registered-read FIFO and sends each one
// as an asynchronous serial frame: start bit, WIDTH data bits LSB first,
// optional even-parity bit, stop bit. Each bit lasts CLKS_PER_BIT clocks.
//
// Build option: define FIFO_READER_TX_PARITY_EN to insert an even-parity bit
// between the last data bit and the stop bit. Left undefined, frames carry no
// parity and no parity logic is built.
//
// All outputs come straight from flops: each output's next value is computed
// together with the next state. Reset is synchronous and active-low.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | line high; waits for tx_en with a non-empty FIFO
// RD       | fifo_rd_en high for this single cycle
// WAIT     | FIFO read data due; load it, or flag underflow and return
// START    | start bit (tx=0)
// DATA     | WIDTH data bits, LSB first
// PARITY   | even-parity bit (parity builds only)
// STOP     | stop bit (tx=1); tx_done pulses as it ends
module fifo_reader_tx #(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tx_en,
  input  logic             fifo_empty,
  output logic             fifo_rd_en,
  input  logic [WIDTH-1:0] fifo_data,
  input  logic             fifo_dvalid,
  output logic             tx,
  output logic             busy,
  output logic             tx_done,
  output logic             rd_err
);

  // Bit-period timer is a down-counter reloaded at every bit boundary; it
  // expires when it reaches zero.
  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_WAIT,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic             tx_q, tx_d;
  logic             busy_q, busy_d;
  logic             rd_en_q, rd_en_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
`ifdef FIFO_READER_TX_PARITY_EN
  logic             par_q, par_d;
`endif

  // State, counters, shift register and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      rd_en_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef FIFO_READER_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      rd_en_q <= rd_en_d;
      done_q  <= done_d;
      err_q   <= err_d;
`ifdef FIFO_READER_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  // Next state plus the value every output takes in that next state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    rd_en_d = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
`ifdef FIFO_READER_TX_PARITY_EN
    par_d   = par_q;
`endif

    case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        if (tx_en && !fifo_empty) begin
          state_d = ST_RD;
          rd_en_d = 1'b1;
        end
      end

      // The read strobe was issued on entry; one cycle here is enough for the
      // FIFO to accept it, so the strobe can never stretch.
      ST_RD: begin
        state_d = ST_WAIT;
      end

      // Data from the FIFO is only looked at here; a missing valid means the
      // FIFO could not serve the read, so the frame is dropped.
      ST_WAIT: begin
        if (fifo_dvalid) begin
          state_d = ST_START;
          shift_d = fifo_data;
          cnt_d   = CNT_LOAD;
          bit_d   = '0;
          tx_d    = 1'b0;
`ifdef FIFO_READER_TX_PARITY_EN
          par_d   = ^fifo_data;
`endif
        end else begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
          tx_d    = 1'b1;
        end
      end

      ST_START: begin
        if (cnt_q == '0) begin
          state_d = ST_DATA;
          cnt_d   = CNT_LOAD;
          tx_d    = shift_q[0];
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      // shift_q[0] is always the bit on the line; shift at each boundary.
      ST_DATA: begin
        if (cnt_q == '0) begin
          cnt_d = CNT_LOAD;
          if (bit_q == LAST_BIT) begin
`ifdef FIFO_READER_TX_PARITY_EN
            state_d = ST_PARITY;
            tx_d    = par_q;
`else
            state_d = ST_STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            bit_d   = bit_q + 1'b1;
            shift_d = shift_q >> 1;
            tx_d    = shift_d[0];
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

`ifdef FIFO_READER_TX_PARITY_EN
      ST_PARITY: begin
        if (cnt_q == '0) begin
          state_d = ST_STOP;
          cnt_d   = CNT_LOAD;
          tx_d    = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
`endif

      ST_STOP: begin
        tx_d = 1'b1;
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  assign fifo_rd_en = rd_en_q;
  assign tx         = tx_q;
  assign busy       = busy_q;
  assign tx_done    = done_q;
  assign rd_err     = err_q;

endmodule

// File: tb/tb_fifo_reader_tx.sv
// Bench for fifo_reader_tx (WIDTH=8, CLKS_PER_BIT=4). A FIFO model answers
// read strobes and queues every delivered word; a monitor rebuilds each frame
// from the queued word and compares the line cycle by cycle.
module tb_fifo_reader_tx;

  localparam int WIDTH = 8;
  localparam int CPB   = 4;
`ifdef FIFO_READER_TX_PARITY_EN
  localparam int NBITS = WIDTH + 3;
`else
  localparam int NBITS = WIDTH + 2;
`endif
  localparam int FRAME_LEN = NBITS * CPB;

  logic             clk;
  logic             rst_n;
  logic             tx_en;
  logic             fifo_empty;
  logic             fifo_rd_en;
  logic [WIDTH-1:0] fifo_data;
  logic             fifo_dvalid;
  logic             tx;
  logic             busy;
  logic             tx_done;
  logic             rd_err;

  logic [7:0] fifo_q[$];
  logic [7:0] exp_q[$];
  int fifo_cnt;
  int n_checks, n_fail;
  int n_rd, n_done, n_err, exp_err, n_pushed;
  bit drop_next, rand_drop;

  assign fifo_empty = (fifo_cnt == 0);

  fifo_reader_tx #(.WIDTH(WIDTH), .CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tx_en      (tx_en),
    .fifo_empty (fifo_empty),
    .fifo_rd_en (fifo_rd_en),
    .fifo_data  (fifo_data),
    .fifo_dvalid(fifo_dvalid),
    .tx         (tx),
    .busy       (busy),
    .tx_done    (tx_done),
    .rd_err     (rd_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Line level for bit slot k of a frame carrying word w.
  function automatic logic exp_level(input logic [7:0] w, input int k);
    if (k == 0) return 1'b0;
    if (k <= WIDTH) return w[k-1];
`ifdef FIFO_READER_TX_PARITY_EN
    if (k == WIDTH + 1) return ($countones(w) % 2) == 1;
`endif
    return 1'b1;
  endfunction

  task automatic push(input logic [7:0] w);
    fifo_q.push_back(w);
    fifo_cnt++;
    n_pushed++;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int target, input int budget);
    int k;
    k = 0;
    while (n_done < target && k < budget) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("tx_done_within_budget", 32'(n_done >= target), 32'(1));
  endtask

  task automatic wait_tx_low(input int budget);
    int k;
    k = 0;
    while (tx !== 1'b0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("start_bit_within_budget", 32'(tx), 32'(0));
  endtask

  // FIFO model: registered read, data valid the cycle after the strobe.
  initial begin : fifo_model
    logic [7:0] w;
    bit drop;
    forever begin
      @(negedge clk);
      if (fifo_rd_en === 1'b1) begin
        @(posedge clk);
        #1;
        if (fifo_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL read_when_empty: fifo_rd_en with an empty FIFO at %0t", $time);
        end else begin
          w = fifo_q.pop_front();
          fifo_cnt--;
          drop = drop_next || (rand_drop && ($urandom_range(0, 9) == 0));
          drop_next = 1'b0;
          if (drop) begin
            exp_err++;
          end else begin
            exp_q.push_back(w);
            fifo_dvalid = 1'b1;
            fifo_data   = w;
          end
          @(posedge clk);
          #1 fifo_dvalid = 1'b0;
        end
      end
    end
  end

  // Monitor: frame checking against the expected-word queue.
  initial begin : monitor
    bit in_frame, had_prev, prev_rd;
    int cyc, gap;
    logic [7:0] cur;
    in_frame = 0; had_prev = 0; prev_rd = 0; cyc = 0; gap = 0; cur = '0;
    forever begin
      @(negedge clk);
      if (tx_done === 1'b1) n_done++;
      if (rd_err === 1'b1) n_err++;
      if (fifo_rd_en === 1'b1) begin
        n_rd++;
        check("rd_en_single_cycle", 32'(prev_rd), 32'(0));
      end
      prev_rd = fifo_rd_en;
      if (rst_n !== 1'b1) begin
        in_frame = 0;
        had_prev = 0;
        gap = 0;
      end else if (in_frame) begin
        if (cyc < FRAME_LEN) begin
          check("tx_bit", 32'(tx), 32'(exp_level(cur, cyc / CPB)));
          check("busy_in_frame", 32'(busy), 32'(1));
          check("no_early_done", 32'(tx_done), 32'(0));
          cyc++;
        end else begin
          check("tx_done_at_frame_end", 32'(tx_done), 32'(1));
          check("tx_idle_after_stop", 32'(tx), 32'(1));
          in_frame = 0;
          had_prev = 1;
          gap = 1;
        end
      end else if (tx === 1'b0) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_frame: tx low with no delivered word at %0t", $time);
          cur = '0;
        end else begin
          cur = exp_q.pop_front();
        end
        if (had_prev) check("inter_frame_gap_ge3", 32'(gap >= 3), 32'(1));
        check("tx_bit", 32'(tx), 32'(exp_level(cur, 0)));
        check("busy_in_frame", 32'(busy), 32'(1));
        cyc = 1;
        in_frame = 1;
      end else begin
        gap++;
        if (tx_done === 1'b1) check("done_outside_frame", 32'(tx_done), 32'(0));
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    int rd0, d0, e0, k;
    n_checks = 0; n_fail = 0; n_rd = 0; n_done = 0; n_err = 0;
    exp_err = 0; n_pushed = 0; fifo_cnt = 0;
    drop_next = 0; rand_drop = 0;
    rst_n = 1'b0; tx_en = 1'b0; fifo_dvalid = 1'b0; fifo_data = '0;

    cycles(3);
    @(negedge clk);
    check("reset_tx", 32'(tx), 32'(1));
    check("reset_busy", 32'(busy), 32'(0));
    check("reset_rd_en", 32'(fifo_rd_en), 32'(0));
    check("reset_tx_done", 32'(tx_done), 32'(0));
    check("reset_rd_err", 32'(rd_err), 32'(0));
    @(posedge clk);
    #1 rst_n = 1'b1;
    cycles(2);

    // Stray read data while idle must not start anything.
    fifo_dvalid = 1'b1; fifo_data = 8'h3C;
    cycles(1);
    fifo_dvalid = 1'b0;
    cycles(3);
    check("dvalid_ignored_busy", 32'(busy), 32'(0));
    check("dvalid_ignored_tx", 32'(tx), 32'(1));

    // 0xA5 with strobe/start latency checks.
    rd0 = n_rd; d0 = n_done;
    push(8'hA5);
    tx_en = 1'b1;
    @(negedge clk);
    check("rd_en_not_same_cycle", 32'(fifo_rd_en), 32'(0));
    @(negedge clk);
    check("rd_en_next_cycle", 32'(fifo_rd_en), 32'(1));
    check("busy_in_rd", 32'(busy), 32'(1));
    @(negedge clk);
    check("rd_en_dropped", 32'(fifo_rd_en), 32'(0));
    check("tx_high_in_wait", 32'(tx), 32'(1));
    @(negedge clk);
    check("start_bit_onset", 32'(tx), 32'(0));
    wait_done(d0 + 1, 200);
    tx_en = 1'b0;
    check("a5_rd_pulses", 32'(n_rd - rd0), 32'(1));

    // 0x07 (parity 1 in parity builds).
    d0 = n_done;
    push(8'h07);
    tx_en = 1'b1;
    wait_done(d0 + 1, 200);
    tx_en = 1'b0;

    // Back-to-back frames.
    rd0 = n_rd; d0 = n_done;
    push(8'h11); push(8'h22);
    tx_en = 1'b1;
    wait_done(d0 + 2, 400);
    tx_en = 1'b0;
    check("b2b_rd_pulses", 32'(n_rd - rd0), 32'(2));

    // Read underflow: no valid after the strobe.
    e0 = n_err;
    drop_next = 1'b1;
    push(8'h5A);
    tx_en = 1'b1;
    k = 0;
    while (n_err == e0 && k < 50) begin
      @(posedge clk);
      #1;
      k++;
    end
    tx_en = 1'b0;
    cycles(5);
    check("rd_err_pulses", 32'(n_err - e0), 32'(1));
    check("rd_err_idle_busy", 32'(busy), 32'(0));
    check("rd_err_idle_tx", 32'(tx), 32'(1));

    // Reset during data bit 3 of 0xFF.
    d0 = n_done;
    push(8'hFF);
    tx_en = 1'b1;
    wait_tx_low(50);
    repeat (17) @(posedge clk);
    #1 rst_n = 1'b0;
    tx_en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midframe_reset_tx", 32'(tx), 32'(1));
    check("midframe_reset_busy", 32'(busy), 32'(0));
    check("midframe_reset_done", 32'(tx_done), 32'(0));
    @(posedge clk);
    #1 rst_n = 1'b1;
    cycles(10);
    check("midframe_reset_no_done", 32'(n_done - d0), 32'(0));
    push(8'h96);
    tx_en = 1'b1;
    wait_done(d0 + 1, 200);
    tx_en = 1'b0;

    // tx_en dropped during the start bit of 0x3C.
    rd0 = n_rd; d0 = n_done;
    push(8'h3C); push(8'h77);
    tx_en = 1'b1;
    wait_tx_low(50);
    tx_en = 1'b0;
    wait_done(d0 + 1, 200);
    cycles(30);
    check("txen_low_rd_pulses", 32'(n_rd - rd0), 32'(1));
    check("txen_low_word_kept", 32'(fifo_cnt), 32'(1));
    check("txen_low_idle", 32'(busy), 32'(0));
    tx_en = 1'b1;
    wait_done(d0 + 2, 200);
    tx_en = 1'b0;

    // Randomized traffic with random enable and occasional underflow.
    rand_drop = 1'b1;
    for (int it = 0; it < 12; it++) begin
      int n;
      n = $urandom_range(1, 3);
      for (int j = 0; j < n; j++) push(8'($urandom_range(0, 255)));
      repeat ($urandom_range(10, 80)) begin
        @(posedge clk);
        #1 tx_en = ($urandom_range(0, 3) != 0);
      end
    end
    tx_en = 1'b1;
    k = 0;
    while (!(fifo_cnt == 0 && busy == 1'b0) && k < 6000) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("random_drained", 32'(fifo_cnt == 0 && busy == 1'b0), 32'(1));
    tx_en = 1'b0;
    rand_drop = 1'b0;
    cycles(5);

    check("all_frames_seen", 32'(exp_q.size()), 32'(0));
    check("rd_err_total", 32'(n_err), 32'(exp_err));
    check("rd_en_total", 32'(n_rd), 32'(n_pushed));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_reader_tx.md
FIFO_READER_TX -- requirements
Module: fifo_reader_tx

Interface
REQ-001 Parameter WIDTH, default 8, data word width in bits (matches FIFO WIDTH).
REQ-002 Parameter CLKS_PER_BIT, default 16, clk cycles per serial bit; legal range >= 2.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst_n  input  1  reset: synchronous, active-low.
REQ-005 tx_en  input  1  permits starting a new frame.
REQ-006 fifo_empty  input  1  FIFO empty flag.
REQ-007 fifo_rd_en  output  1  FIFO read request; one-cycle pulse.
REQ-008 fifo_data  input  WIDTH  FIFO registered read data.
REQ-009 fifo_dvalid  input  1  FIFO read-data valid, one cycle after the accepted read.
REQ-010 tx  output  1  serial line; idle high.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 tx_done  output  1  one-cycle pulse when a stop bit completes.
REQ-013 rd_err  output  1  one-cycle pulse on read underflow (REQ-019).

Function
REQ-014 The FSM SHALL have states IDLE, RD, WAIT, START, DATA, PARITY, STOP; all outputs registered.
REQ-015 IDLE: if tx_en=1 and fifo_empty=0 in cycle T, fifo_rd_en SHALL be 1 in cycle T+1 only (state RD).
REQ-016 RD SHALL always move to WAIT after one cycle; fifo_rd_en SHALL never be high for two consecutive cycles.
REQ-017 WAIT with fifo_dvalid=1 in cycle T+2 SHALL load fifo_data into the shift register and enter START; tx SHALL be 0 from cycle T+3.
REQ-018 Each of the start, data, parity and stop bits SHALL hold tx for exactly CLKS_PER_BIT cycles using a bit-period counter that resets at each bit boundary.
REQ-019 WAIT with fifo_dvalid=0 SHALL pulse rd_err for one cycle, return to IDLE, and keep tx=1.
REQ-020 DATA SHALL send WIDTH bits LSB first; a bit counter of width $clog2(WIDTH)+1 SHALL select the next state after bit WIDTH-1.
REQ-021 STOP SHALL drive tx=1; at the end of its last cycle tx_done SHALL pulse for one cycle and the FSM SHALL enter IDLE.
REQ-022 Back-to-back: the next fifo_rd_en SHALL occur no earlier than the cycle after IDLE is entered, giving an idle-high gap of >= 3 cycles between frames.
REQ-023 Deasserting tx_en mid-frame SHALL NOT abort the frame; it only blocks the next start.
REQ-024 fifo_dvalid outside WAIT SHALL be ignored.
REQ-025 Frame length SHALL be (WIDTH+2)*CLKS_PER_BIT cycles without parity and (WIDTH+3)*CLKS_PER_BIT cycles with parity.

Reset
REQ-026 With rst_n=0 at a clock edge, the FSM SHALL enter IDLE, and tx=1, busy=0, fifo_rd_en=0, tx_done=0, rd_err=0 after that edge.
REQ-027 All counters and the shift register SHALL clear to 0 on reset.
REQ-028 Reset mid-frame SHALL abort the frame with no tx_done; a word already popped from the FIFO is discarded.

Configuration
REQ-029 Macro FIFO_READER_TX_PARITY_EN defined: the PARITY state SHALL be inserted between DATA and STOP and SHALL transmit the even-parity bit (XOR of the data bits).
REQ-030 Macro FIFO_READER_TX_PARITY_EN undefined: DATA SHALL go directly to STOP, and no parity logic SHALL exist.

Verification (WIDTH=8, CLKS_PER_BIT=4)
REQ-031 FIFO holds 0xA5, tx_en=1 -> one fifo_rd_en pulse; tx sequence 0,1,0,1,0,0,1,0,1,1 with 4 cycles per bit; tx_done 40 cycles after start-bit onset.
REQ-032 FIFO_READER_TX_PARITY_EN defined, word 0xA5 -> parity bit 0 before stop; word 0x07 -> parity bit 1; frame is 44 cycles.
REQ-033 FIFO holds 0x11 then 0x22, tx_en held at 1 -> two complete frames, exactly two fifo_rd_en pulses, tx high for >= 3 cycles between frames.
REQ-034 fifo_dvalid held at 0 after fifo_rd_en -> rd_err pulses once, tx stays 1, FSM returns to IDLE.
REQ-035 rst_n=0 during data bit 3 of 0xFF -> next cycle tx=1, busy=0, no tx_done; the next word transmits cleanly.
REQ-036 tx_en dropped during START of 0x3C -> the frame completes with tx_done; no further fifo_rd_en while tx_en=0 and fifo_empty=0.
